// File: rtl/syscheck_seq_pkg.sv
// Shared types and constants for the CPU strap validation sequencer.
package syscheck_seq_pkg;

    // Width of the concatenated strap vector.
    localparam int STRAP_W = 14;

    // Bit position of invCPUSktOcc[0] (CPU0 occupied, active-low) in the strap vector.
    localparam int OCC_LSB = 12;

    // Snapshot reset value: both sockets reported empty, all IDs zero.
    localparam logic [STRAP_W-1:0] STRAP_RST = {2'b11, 12'b0};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_UNSTABLE = 3'd1,
        FLT_MISMATCH = 3'd2,
        FLT_SKT_CHG  = 3'd3,
        FLT_NO_CPU0  = 3'd4
    } fault_e;

endpackage

// File: rtl/syscheck_sequencer_filter.sv
// Strap stability filter: counts consecutive identical samples and glitches.
// oDone/oFail are combinational and refer to the sample taken this cycle.
module strap_stability_filter
    import syscheck_seq_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned MAX_GLITCH     = 3
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iClear,
    input  logic [STRAP_W-1:0] ivStraps,
    output logic               oDone,
    output logic               oFail
);

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_SAMPLES - 1);
    localparam logic [3:0] GLITCH_LAST = 4'(MAX_GLITCH);

    logic [STRAP_W-1:0] prev_q;
    logic [7:0]         stable_q, stable_d;
    logic [3:0]         glitch_q, glitch_d;

    // Previous-cycle vector and counters; prev tracks the live vector every cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (iRst) begin
            prev_q   <= '0;
            stable_q <= '0;
            glitch_q <= '0;
        end else begin
            prev_q   <= ivStraps;
            stable_q <= stable_d;
            glitch_q <= glitch_d;
        end
    end

    // Compare against the previous sample; a mismatch never reports done.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        stable_d = stable_q;
        glitch_d = glitch_q;
        oDone    = 1'b0;
        oFail    = 1'b0;
        if (iClear) begin
            stable_d = '0;
            glitch_d = '0;
        end else if (ivStraps == prev_q) begin
            oDone    = (stable_q == STABLE_LAST);
            stable_d = stable_q + 8'd1;
        end else begin
            oFail    = (glitch_q == GLITCH_LAST);
            stable_d = '0;
            glitch_d = glitch_q + 4'd1;
        end
    end

endmodule

// File: rtl/syscheck_sequencer.sv
// CPU strap validation sequencer: settle, sample until stable, freeze a
// snapshot for the SysCheck comparator, then grant CPU power-on or fault.
module syscheck_sequencer
    import syscheck_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned MAX_GLITCH     = 3,
    parameter int unsigned CHECK_LATENCY  = 3
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iAuxPwrDone,
    input  logic [1:0] invCPUSktOcc,
    input  logic [1:0] ivIntr,
    input  logic [1:0] ivProcIDCPU1,
    input  logic [1:0] ivProcIDCPU2,
    input  logic [2:0] ivPkgIDCPU1,
    input  logic [2:0] ivPkgIDCPU2,
    input  logic       iSysOk,
    input  logic       iClear,
    output logic [1:0] onvCPUSktOccL,
    output logic [1:0] ovIntrL,
    output logic [1:0] ovProcIDCPU1L,
    output logic [1:0] ovProcIDCPU2L,
    output logic [2:0] ovPkgIDCPU1L,
    output logic [2:0] ovPkgIDCPU2L,
    output logic       oStrapsValid,
    output logic       oCpuGo,
    output logic       oFault,
    output logic [2:0] ovFaultCode
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_LATENCY);

    logic [STRAP_W-1:0] straps_live;
    logic [STRAP_W-1:0] snap_q;
    state_e             state_q, state_d;
    fault_e             code_q, code_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               valid_q, go_q, fault_q;
    logic               snap_load;
    logic               filt_clear, filt_done, filt_fail;

    assign straps_live = {invCPUSktOcc, ivIntr, ivProcIDCPU2, ivProcIDCPU1,
                          ivPkgIDCPU2, ivPkgIDCPU1};

    // Filter counters only run while sampling.
    assign filt_clear = (state_q != ST_SAMPLE);

    strap_stability_filter #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .MAX_GLITCH     (MAX_GLITCH)
    ) u_filter (
        .iClk     (iClk),
        .iRst     (iRst),
        .iClear   (filt_clear),
        .ivStraps (straps_live),
        .oDone    (filt_done),
        .oFail    (filt_fail)
    );

    // Next-state, fault code and snapshot-load decode; aux loss outranks everything but FAULT.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        snap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iAuxPwrDone) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!iAuxPwrDone)              state_d = ST_IDLE;
                else if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!iAuxPwrDone) begin
                    state_d = ST_IDLE;
                end else if (filt_fail) begin
                    state_d = ST_FAULT;
                    code_d  = FLT_UNSTABLE;
                end else if (filt_done) begin
                    snap_load = 1'b1;
                    if (straps_live[OCC_LSB]) begin
                        state_d = ST_FAULT;
                        code_d  = FLT_NO_CPU0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (!iAuxPwrDone) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CHECK_LAST) begin
                    if (iSysOk) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FLT_MISMATCH;
                    end
                end
            end
            ST_RUN: begin
                if (!iAuxPwrDone) begin
                    state_d = ST_IDLE;
                end else if (invCPUSktOcc != snap_q[OCC_LSB +: 2]) begin
                    state_d = ST_FAULT;
                    code_d  = FLT_SKT_CHG;
                end
            end
            ST_FAULT: begin
                if (iClear) begin
                    state_d = iAuxPwrDone ? ST_SETTLE : ST_IDLE;
                    code_d  = FLT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                code_d  = FLT_NONE;
            end
        endcase
    end

    // Wait counter restarts on every state change and only counts in SETTLE and CHECK.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ST_SETTLE) || (state_q == ST_CHECK))) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State, counter, snapshot and registered outputs decoded from the next state.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            code_q  <= FLT_NONE;
            cnt_q   <= '0;
            snap_q  <= STRAP_RST;
            valid_q <= 1'b0;
            go_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            if (snap_load) snap_q <= straps_live;
            valid_q <= (state_d == ST_CHECK) || (state_d == ST_RUN);
            go_q    <= (state_d == ST_RUN);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign onvCPUSktOccL = snap_q[13:12];
    assign ovIntrL       = snap_q[11:10];
    assign ovProcIDCPU2L = snap_q[9:8];
    assign ovProcIDCPU1L = snap_q[7:6];
    assign ovPkgIDCPU2L  = snap_q[5:3];
    assign ovPkgIDCPU1L  = snap_q[2:0];
    assign oStrapsValid  = valid_q;
    assign oCpuGo        = go_q;
    assign oFault        = fault_q;
    assign ovFaultCode   = code_q;

endmodule

// File: tb/tb_syscheck_sequencer.sv
// Directed testbench for syscheck_sequencer with short settle/sample settings.
module tb_syscheck_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       aux = 1'b0;
    logic [1:0] occ_n = 2'b00;
    logic [1:0] intr = 2'b00;
    logic [1:0] pid1 = 2'b01;
    logic [1:0] pid2 = 2'b10;
    logic [2:0] pkg1 = 3'b011;
    logic [2:0] pkg2 = 3'b101;
    logic       sys_ok = 1'b1;
    logic       clr = 1'b0;

    logic [1:0] occ_l, intr_l, pid1_l, pid2_l;
    logic [2:0] pkg1_l, pkg2_l, code;
    logic       valid, go, fault;

    int checks = 0;
    int errors = 0;
    int tv, tg, tf;

    localparam logic [13:0] SNAP_GOOD = {2'b00, 2'b00, 2'b10, 2'b01, 3'b101, 3'b011};

    syscheck_sequencer #(
        .SETTLE_CYCLES  (10),
        .STABLE_SAMPLES (4),
        .MAX_GLITCH     (3),
        .CHECK_LATENCY  (3)
    ) dut (
        .iClk          (clk),
        .iRst          (rst),
        .iAuxPwrDone   (aux),
        .invCPUSktOcc  (occ_n),
        .ivIntr        (intr),
        .ivProcIDCPU1  (pid1),
        .ivProcIDCPU2  (pid2),
        .ivPkgIDCPU1   (pkg1),
        .ivPkgIDCPU2   (pkg2),
        .iSysOk        (sys_ok),
        .iClear        (clr),
        .onvCPUSktOccL (occ_l),
        .ovIntrL       (intr_l),
        .ovProcIDCPU1L (pid1_l),
        .ovProcIDCPU2L (pid2_l),
        .ovPkgIDCPU1L  (pkg1_l),
        .ovPkgIDCPU2L  (pkg2_l),
        .oStrapsValid  (valid),
        .oCpuGo        (go),
        .oFault        (fault),
        .ovFaultCode   (code)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] snap();
        return {occ_l, intr_l, pid2_l, pid1_l, pkg2_l, pkg1_l};
    endfunction

    // Run a bounded number of edges, recording the first edge each output went high.
    task automatic measure(input int budget);
        tv = 0; tg = 0; tf = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (valid && tv == 0) tv = n;
            if (go && tg == 0)    tg = n;
            if (fault && tf == 0) tf = n;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; aux = 1'b0; clr = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic set_good_straps();
        occ_n = 2'b00; intr = 2'b00; pid1 = 2'b01; pid2 = 2'b10; pkg1 = 3'b011; pkg2 = 3'b101;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b expected 0", go); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", code); end
        checks++; if (snap() !== 14'h3000) begin errors++; $display("FAIL reset_snapshot: got %h expected 3000", snap()); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_nominal();
        set_good_straps(); sys_ok = 1'b1;
        @(negedge clk); aux = 1'b1;
        measure(30);
        checks++; if (tv != 15) begin errors++; $display("FAIL nominal_valid_cycle: got %0d expected 15", tv); end
        checks++; if (tg != 19) begin errors++; $display("FAIL nominal_go_cycle: got %0d expected 19", tg); end
        checks++; if (tf != 0) begin errors++; $display("FAIL nominal_no_fault: fault at %0d expected none", tf); end
        checks++; if (snap() !== SNAP_GOOD) begin errors++; $display("FAIL nominal_snapshot: got %h expected %h", snap(), SNAP_GOOD); end
        checks++; if (valid !== 1'b1 || go !== 1'b1) begin errors++; $display("FAIL nominal_run_outputs: got valid=%b go=%b expected 1 1", valid, go); end
    endtask

    task automatic test_socket_change();
        @(negedge clk); occ_n = 2'b10;
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL skt_go_before_edge: got %b expected 1", go); end
        @(posedge clk); #1;
        checks++; if (go !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL skt_go_fault: got go=%b fault=%b expected 0 1", go, fault); end
        checks++; if (code !== 3'd3) begin errors++; $display("FAIL skt_code: got %0d expected 3", code); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL skt_valid: got %b expected 0", valid); end
        checks++; if (occ_l !== 2'b00) begin errors++; $display("FAIL skt_snapshot_held: got %b expected 00", occ_l); end
    endtask

    task automatic test_mismatch_and_clear();
        @(negedge clk); aux = 1'b0; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        checks++; if (fault !== 1'b0 || code !== 3'd0) begin errors++; $display("FAIL clr_idle: got fault=%b code=%0d expected 0 0", fault, code); end
        occ_n = 2'b00; sys_ok = 1'b0;
        @(negedge clk); aux = 1'b1;
        measure(25);
        checks++; if (tv != 15) begin errors++; $display("FAIL mm_valid_cycle: got %0d expected 15", tv); end
        checks++; if (tf != 19) begin errors++; $display("FAIL mm_fault_cycle: got %0d expected 19", tf); end
        checks++; if (code !== 3'd2) begin errors++; $display("FAIL mm_code: got %0d expected 2", code); end
        checks++; if (tg != 0 || valid !== 1'b0) begin errors++; $display("FAIL mm_no_go: got go_cycle=%0d valid=%b expected 0 0", tg, valid); end
        sys_ok = 1'b1;
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        checks++; if (fault !== 1'b0 || code !== 3'd0) begin errors++; $display("FAIL clr_resettle: got fault=%b code=%0d expected 0 0", fault, code); end
        measure(25);
        checks++; if (tv != 14) begin errors++; $display("FAIL resettle_valid: got %0d expected 14", tv); end
        checks++; if (tg != 18) begin errors++; $display("FAIL resettle_go: got %0d expected 18", tg); end
    endtask

    task automatic test_glitch();
        apply_reset(); set_good_straps(); sys_ok = 1'b1;
        @(negedge clk); aux = 1'b1;
        repeat (11) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); intr = intr ^ 2'b01;
            @(posedge clk); #1;
            if (i == 2) begin
                checks++; if (fault !== 1'b0) begin errors++; $display("FAIL glitch_three_tolerated: got %b expected 0", fault); end
            end
        end
        checks++; if (fault !== 1'b1 || code !== 3'd1) begin errors++; $display("FAIL glitch_fault: got fault=%b code=%0d expected 1 1", fault, code); end
        measure(6);
        checks++; if (tg != 0 || tv != 0) begin errors++; $display("FAIL glitch_no_go: got go=%0d valid=%0d expected 0 0", tg, tv); end
    endtask

    task automatic test_mismatch_wins();
        apply_reset(); set_good_straps(); sys_ok = 1'b1;
        @(negedge clk); aux = 1'b1;
        repeat (14) @(posedge clk);
        @(negedge clk); intr = 2'b01;
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL late_glitch: got valid=%b fault=%b expected 0 0", valid, fault); end
        measure(10);
        checks++; if (tv != 4 || tg != 8) begin errors++; $display("FAIL late_glitch_recover: got valid=%0d go=%0d expected 4 8", tv, tg); end
    endtask

    task automatic test_no_cpu0();
        apply_reset(); set_good_straps(); occ_n = 2'b01;
        @(negedge clk); aux = 1'b1;
        measure(20);
        checks++; if (tf != 15 || code !== 3'd4) begin errors++; $display("FAIL no_cpu0: got fault_cycle=%0d code=%0d expected 15 4", tf, code); end
        checks++; if (tv != 0 || tg != 0) begin errors++; $display("FAIL no_cpu0_valid: got valid=%0d go=%0d expected 0 0", tv, tg); end
        checks++; if (occ_l !== 2'b01) begin errors++; $display("FAIL no_cpu0_snapshot: got %b expected 01", occ_l); end
    endtask

    task automatic test_aux_drop_check();
        apply_reset(); set_good_straps(); sys_ok = 1'b0;
        @(negedge clk); aux = 1'b1;
        repeat (16) @(posedge clk); #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drop_in_check: got %b expected 1", valid); end
        repeat (2) @(posedge clk);
        @(negedge clk); aux = 1'b0;
        measure(4);
        checks++; if (tf != 0 || valid !== 1'b0 || go !== 1'b0 || code !== 3'd0) begin
            errors++; $display("FAIL drop_wins: got fault=%0d valid=%b go=%b code=%0d expected 0 0 0 0", tf, valid, go, code);
        end
    endtask

    task automatic test_rst_mid_sample();
        sys_ok = 1'b1;
        @(negedge clk); aux = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (valid !== 1'b0 || go !== 1'b0 || fault !== 1'b0 || code !== 3'd0) begin
            errors++; $display("FAIL rst_async_outputs: got valid=%b go=%b fault=%b code=%0d expected 0 0 0 0", valid, go, fault, code);
        end
        checks++; if (snap() !== 14'h3000) begin errors++; $display("FAIL rst_async_snapshot: got %h expected 3000", snap()); end
        @(negedge clk); rst = 1'b0;
        measure(25);
        checks++; if (tv != 15 || tg != 19 || tf != 0) begin errors++; $display("FAIL rst_revalidate: got valid=%0d go=%0d fault=%0d expected 15 19 0", tv, tg, tf); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_socket_change();
        test_mismatch_and_clear();
        test_glitch();
        test_mismatch_wins();
        test_no_cpu0();
        test_aux_drop_check();
        test_rst_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
